// File: rtl/o_feature_writeback_pkg.sv
// Shared constants, opcodes and FSM state type for the output feature writeback path.
package o_feature_writeback_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_BUS_W  = 128;
    localparam int DEF_ADDR_W = 15;

    localparam logic [6:0] OP_NOP     = 7'd0;
    localparam logic [6:0] OP_FETCH   = 7'd1;
    localparam logic [6:0] OP_COMPUTE = 7'd2;
    localparam logic [6:0] OP_WB      = 7'd3;

    // Largest edge whose square still fits the 2^15-word feature_out memory.
    localparam logic [7:0] MAX_FEATURE_SIZE = 8'd181;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } wb_state_e;

    function automatic logic size_legal(input logic [7:0] n);
        return (n != 8'd0) && (n <= MAX_FEATURE_SIZE);
    endfunction

endpackage

// File: rtl/o_feature_pack.sv
// Collects one beat of elements from the feature_out read port into a lane register.
// Optional ReLU on capture when O_FEATURE_RELU_EN is defined.
module o_feature_pack
    import o_feature_writeback_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_BUS_W / DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    rd_en,
    input  logic [DATA_W-1:0]       rd_data,
    output logic [LANES*DATA_W-1:0] beat_data
);

    localparam int LANE_W = $clog2(LANES + 1);

    logic                    rd_en_q;
    logic [LANE_W-1:0]       lane_q;
    logic [LANES*DATA_W-1:0] data_q;

    function automatic logic [DATA_W-1:0] shape(input logic [DATA_W-1:0] x);
`ifdef O_FEATURE_RELU_EN
        return x[DATA_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Clearing the whole register at beat start is what zero-pads a short final beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q <= 1'b0;
            lane_q  <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this block
            // reading pre-edge values, independent of statement order.
            rd_en_q <= rd_en;
            if (clear) begin
                lane_q <= '0;
                data_q <= '0;
            end else if (rd_en_q) begin
                data_q[int'(lane_q)*DATA_W +: DATA_W] <= shape(rd_data);
                lane_q <= lane_q + LANE_W'(1);
            end
        end
    end

    assign beat_data = data_q;

endmodule

// File: rtl/o_feature_writeback.sv
// Drains an N*N output feature map from feature_out memory into 128-bit external beats.
// Build option: define O_FEATURE_RELU_EN to zero negative elements on the way out.
module o_feature_writeback
    import o_feature_writeback_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BUS_W  = DEF_BUS_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        opcode,
    input  logic [7:0]        feature_size,
    input  logic              feature_out_select,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              o_mem_select,
    output logic [BUS_W-1:0]  o_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              o_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int LANES  = BUS_W / DATA_W;
    localparam int LANE_W = $clog2(LANES + 1);

    wb_state_e         state_q, state_d;
    logic [6:0]        opcode_q;
    logic [15:0]       remaining_q;
    logic [LANE_W-1:0] issue_q;
    logic [ADDR_W-1:0] addr_q;
    logic              mem_sel_q;
    logic              err_q;

    logic              start_req;
    logic              size_ok;
    logic              issue;
    logic              handshake;
    logic              beat_clear;
    logic [15:0]       total;
    logic [BUS_W-1:0]  beat_data;

    assign total      = 16'(feature_size) * 16'(feature_size);
    assign size_ok    = size_legal(feature_size);
    assign start_req  = (opcode == OP_WB) && (opcode_q != OP_WB) && (state_q == IDLE);
    assign issue      = (state_q == READ) && (remaining_q != 16'd0) && (issue_q != LANE_W'(LANES));
    assign handshake  = (state_q == SEND) && o_ready;
    assign beat_clear = (start_req && size_ok) || (handshake && (remaining_q != 16'd0));

    // READ ends on the first cycle with nothing to issue: the final capture lands on that edge.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_req && size_ok) state_d = READ;
            READ: if (!issue) state_d = SEND;
            SEND: if (o_ready) state_d = (remaining_q == 16'd0) ? DONE : READ;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            opcode_q    <= OP_NOP;
            remaining_q <= '0;
            issue_q     <= '0;
            addr_q      <= '0;
            mem_sel_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode;
            if (start_req) begin
                if (size_ok) begin
                    err_q       <= 1'b0;
                    mem_sel_q   <= feature_out_select;
                    remaining_q <= total;
                    addr_q      <= '0;
                    issue_q     <= '0;
                end else begin
                    err_q <= 1'b1;
                end
            end else begin
                if (issue) begin
                    remaining_q <= remaining_q - 16'd1;
                    issue_q     <= issue_q + LANE_W'(1);
                    // Hold on the final element so rd_addr never passes total-1.
                    if (remaining_q != 16'd1) addr_q <= addr_q + ADDR_W'(1);
                end
                if (handshake) issue_q <= '0;
            end
        end
    end

    o_feature_pack #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_pack (
        .clk       (clk),
        .rst       (rst),
        .clear     (beat_clear),
        .rd_en     (issue),
        .rd_data   (rd_data),
        .beat_data (beat_data)
    );

    assign rd_en        = issue;
    assign rd_addr      = addr_q;
    assign o_mem_select = mem_sel_q;
    assign o_valid      = (state_q == SEND);
    assign o_data       = o_valid ? beat_data : '0;
    assign o_last       = o_valid && (remaining_q == 16'd0);
    assign busy         = (state_q == READ) || (state_q == SEND);
    assign done         = (state_q == DONE);
    assign err          = err_q;

endmodule
